// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide single-port synchronous RAM (RMW for sub-word stores).
// Optional `MEM_BOUNDS_CHECK_EN flags requests whose address lies above the RAM window.
module mem_access_unit #(
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    // state  | meaning
    // IDLE   | ready for a request
    // RD     | word address presented for read
    // CAP    | read data returned; extract lane or merge store data
    // WR     | single-cycle RAM write
    // RESP   | one-cycle response pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    logic [2:0]  state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic        out_of_range;
    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [31:0] merge_data;

`ifdef MEM_BOUNDS_CHECK_EN
    assign out_of_range = |req_addr[31:MEM_ADDR_W+2];
`else
    // Upper address bits are don't-care: accesses wrap within the RAM window.
    logic unused_hi_addr;
    assign out_of_range   = 1'b0;
    assign unused_hi_addr = ^req_addr[31:MEM_ADDR_W+2];
`endif

    always_comb begin
        req_err = (req_size == SZ_ILL)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
               || out_of_range;
    end

    always_comb begin
        lane_byte = mem_rdata[{lat_lane, 3'b000} +: 8];
        lane_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            SZ_BYTE: load_data = {{24{~lat_unsigned & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{~lat_unsigned & lane_half[15]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Only the addressed lane(s) change; everything else comes from the read word.
    always_comb begin
        merge_data = mem_rdata;
        if (lat_size == SZ_BYTE) begin
            merge_data[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
        end else if (lat_lane[1]) begin
            merge_data[31:16] = lat_wdata;
        end else begin
            merge_data[15:0] = lat_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
            lat_wdata    <= 16'h0000;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0000_0000;
            resp_rdata   <= 32'h0000_0000;
            resp_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write    <= req_write;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_lane     <= req_addr[1:0];
                        lat_wdata    <= req_wdata[15:0];
                        if (req_err) begin
                            resp_rdata <= 32'h0000_0000;
                            resp_error <= 1'b1;
                            state      <= S_RESP;
                        end else if (req_write && req_size == SZ_WORD) begin
                            mem_addr  <= req_addr[MEM_ADDR_W+1:2];
                            mem_wdata <= req_wdata;
                            state     <= S_WR;
                        end else begin
                            mem_addr <= req_addr[MEM_ADDR_W+1:2];
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    if (lat_write) begin
                        mem_wdata <= merge_data;
                        state     <= S_WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_error <= 1'b0;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    resp_rdata <= 32'h0000_0000;
                    resp_error <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from state so the write strobe drops with reset asynchronously.
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_write  = (state == S_WR);

endmodule
